// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Streams a program image into a processor's instruction memory. The first
//   accepted word is a header holding the instruction count N. The next N
//   words are written to consecutive word addresses starting at byte 0. The
//   processor is held in reset for the whole load. It is released only after
//   the final write strobe has been issued.
//
// Ports
//   clk           : single clock, rising-edge active
//   reset         : synchronous active-high reset
//   start         : begin or restart a load (only honoured in IDLE/DONE/ERR)
//   s_valid       : upstream word valid
//   s_data        : upstream word (header, then instructions)
//   s_ready       : loader accepts s_data this cycle (HEADER and LOAD only)
//   instr_in      : instruction memory write data
//   instr_wr_addr : instruction memory byte address
//   instr_wr_en   : instruction memory write strobe, one pulse per word
//   cpu_reset     : processor reset, high in every state except DONE
//   load_done     : program loaded and processor released
//   load_err      : header count exceeded SIZE
//
// SIZE must be at least 2 so that LOGSIZE is non-zero.
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               s_valid,
  input  logic [WIDTH-1:0]   s_data,
  output logic               s_ready,
  output logic [WIDTH-1:0]   instr_in,
  output logic [$clog2(SIZE)+1:0] instr_wr_addr,
  output logic               instr_wr_en,
  output logic               cpu_reset,
  output logic               load_done,
  output logic               load_err
);

  localparam int LOGSIZE = $clog2(SIZE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    LOAD   = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       n_q, n_d;
  // One extra bit so the counter can reach SIZE without wrapping.
  logic [LOGSIZE:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       instr_q, instr_d;
  logic [LOGSIZE+1:0]     addr_q, addr_d;
  logic                   wr_en_q, wr_en_d;
  logic                   s_ready_q, s_ready_d;
  logic                   cpu_reset_q, cpu_reset_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   hs_s;
  logic                   last_s;

  // The handshake uses the registered ready, so acceptance is known at the edge.
  assign hs_s   = s_valid & s_ready_q;
  assign last_s = ({{(WIDTH-LOGSIZE-1){1'b0}}, cnt_q} == (n_q - {{(WIDTH-1){1'b0}}, 1'b1}));

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    wr_en_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HEADER;
        end else begin
          state_d = IDLE;
        end
      end
      HEADER: begin
        if (hs_s) begin
          n_d   = s_data;
          cnt_d = {(LOGSIZE+1){1'b0}};
          if (s_data == {WIDTH{1'b0}}) begin
            state_d = DONE;
          end else if (s_data > WIDTH'(SIZE)) begin
            state_d = ERR;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = HEADER;
        end
      end
      LOAD: begin
        if (hs_s) begin
          wr_en_d = 1'b1;
          instr_d = s_data;
          addr_d  = {cnt_q[LOGSIZE-1:0], 2'b00};
          cnt_d   = cnt_q + {{LOGSIZE{1'b0}}, 1'b1};
          if (last_s) begin
            state_d = DRAIN;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      // The final write strobe is visible during DRAIN; the CPU is released after it.
      DRAIN: begin
        state_d = DONE;
      end
      DONE, ERR: begin
        if (start) begin
          state_d = HEADER;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are decoded from the next state so they register with it.
    s_ready_d   = (state_d == HEADER) || (state_d == LOAD);
    cpu_reset_d = (state_d != DONE);
    done_d      = (state_d == DONE);
    err_d       = (state_d == ERR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= {WIDTH{1'b0}};
      cnt_q       <= {(LOGSIZE+1){1'b0}};
      instr_q     <= {WIDTH{1'b0}};
      addr_q      <= {(LOGSIZE+2){1'b0}};
      wr_en_q     <= 1'b0;
      s_ready_q   <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      s_ready_q   <= s_ready_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign instr_in      = instr_q;
  assign instr_wr_addr = addr_q;
  assign instr_wr_en   = wr_en_q;
  assign cpu_reset     = cpu_reset_q;
  assign load_done     = done_q;
  assign load_err      = err_q;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Directed self-checking bench for program_loader (WIDTH=32, SIZE=64).
//   Inputs change 1 time unit after each rising edge; outputs are sampled at
//   the same point, i.e. they show the registers updated by that edge.
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam int WIDTH = 32;
  localparam int SIZE  = 64;
  localparam int AW    = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic [WIDTH-1:0] instr_in;
  logic [AW-1:0]    instr_wr_addr;
  logic             instr_wr_en;
  logic             cpu_reset;
  logic             load_done;
  logic             load_err;

  int n_total;
  int n_bad;

  logic [AW-1:0]    wa_q[$];
  logic [WIDTH-1:0] wd_q[$];

  program_loader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .instr_in      (instr_in),
    .instr_wr_addr (instr_wr_addr),
    .instr_wr_en   (instr_wr_en),
    .cpu_reset     (cpu_reset),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe.
  always @(negedge clk) begin
    if (instr_wr_en === 1'b1) begin
      wa_q.push_back(instr_wr_addr);
      wd_q.push_back(instr_in);
    end
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic xfer(input logic [WIDTH-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic clr_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 32'h0;
    step();
    step();

    // Reset state, with start asserted to show reset wins.
    start = 1'b1;
    step();
    start = 1'b0;
    chk_val("rst_s_ready",   64'(s_ready), 64'd0);
    chk_val("rst_wr_en",     64'(instr_wr_en), 64'd0);
    chk_val("rst_instr_in",  64'(instr_in), 64'd0);
    chk_val("rst_addr",      64'(instr_wr_addr), 64'd0);
    chk_val("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk_val("rst_done",      64'(load_done), 64'd0);
    chk_val("rst_err",       64'(load_err), 64'd0);
    reset = 1'b0;
    step();
    chk_val("idle_s_ready",  64'(s_ready), 64'd0);

    // Three words streamed back to back.
    clr_log();
    do_start();
    chk_val("hdr_s_ready",   64'(s_ready), 64'd1);
    xfer(32'd3);
    chk_val("t1_hdr_no_wr",  64'(instr_wr_en), 64'd0);
    xfer(32'h0050_0093);
    chk_val("t1_w0_en",      64'(instr_wr_en), 64'd1);
    chk_val("t1_w0_addr",    64'(instr_wr_addr), 64'd0);
    chk_val("t1_w0_data",    64'(instr_in), 64'h0050_0093);
    xfer(32'h00A0_0113);
    chk_val("t1_w1_en",      64'(instr_wr_en), 64'd1);
    chk_val("t1_w1_addr",    64'(instr_wr_addr), 64'd4);
    chk_val("t1_w1_data",    64'(instr_in), 64'h00A0_0113);
    xfer(32'h0020_81B3);
    chk_val("t1_w2_en",      64'(instr_wr_en), 64'd1);
    chk_val("t1_w2_addr",    64'(instr_wr_addr), 64'd8);
    chk_val("t1_w2_data",    64'(instr_in), 64'h0020_81B3);
    chk_val("t1_w2_cpurst",  64'(cpu_reset), 64'd1);
    chk_val("t1_w2_ready",   64'(s_ready), 64'd0);
    step();
    chk_val("t1_end_en",     64'(instr_wr_en), 64'd0);
    chk_val("t1_end_cpurst", 64'(cpu_reset), 64'd0);
    chk_val("t1_end_done",   64'(load_done), 64'd1);
    chk_val("t1_nwr",        64'(wa_q.size()), 64'd3);

    // Two words with stall gaps; start during the load is ignored.
    clr_log();
    do_start();
    chk_val("t2_restart_cpurst", 64'(cpu_reset), 64'd1);
    chk_val("t2_restart_done",   64'(load_done), 64'd0);
    xfer(32'd2);
    xfer(32'hDEAD_0001);
    chk_val("t2_w0_en",      64'(instr_wr_en), 64'd1);
    chk_val("t2_w0_addr",    64'(instr_wr_addr), 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_val("t2_gap1_en",    64'(instr_wr_en), 64'd0);
    chk_val("t2_gap1_ready", 64'(s_ready), 64'd1);
    chk_val("t2_gap1_addr",  64'(instr_wr_addr), 64'd0);
    step();
    chk_val("t2_gap2_en",    64'(instr_wr_en), 64'd0);
    xfer(32'hBEEF_0002);
    chk_val("t2_w1_en",      64'(instr_wr_en), 64'd1);
    chk_val("t2_w1_addr",    64'(instr_wr_addr), 64'd4);
    chk_val("t2_w1_data",    64'(instr_in), 64'hBEEF_0002);
    step();
    chk_val("t2_done",       64'(load_done), 64'd1);
    chk_val("t2_nwr",        64'(wa_q.size()), 64'd2);

    // Oversized header, then recovery with a one-word load.
    clr_log();
    do_start();
    xfer(32'd65);
    chk_val("t3_err",        64'(load_err), 64'd1);
    chk_val("t3_err_cpurst", 64'(cpu_reset), 64'd1);
    chk_val("t3_err_ready",  64'(s_ready), 64'd0);
    step();
    chk_val("t3_err_nwr",    64'(wa_q.size()), 64'd0);
    do_start();
    chk_val("t3_err_clr",    64'(load_err), 64'd0);
    xfer(32'd1);
    xfer(32'h0000_0013);
    chk_val("t3_w0_en",      64'(instr_wr_en), 64'd1);
    chk_val("t3_w0_addr",    64'(instr_wr_addr), 64'd0);
    chk_val("t3_w0_data",    64'(instr_in), 64'h0000_0013);
    step();
    chk_val("t3_done",       64'(load_done), 64'd1);
    chk_val("t3_nwr",        64'(wa_q.size()), 64'd1);

    // Zero-length program.
    clr_log();
    do_start();
    xfer(32'd0);
    chk_val("t4_done",       64'(load_done), 64'd1);
    chk_val("t4_cpurst",     64'(cpu_reset), 64'd0);
    step();
    chk_val("t4_nwr",        64'(wa_q.size()), 64'd0);

    // Reset in the middle of a load, with a word offered in the same cycle.
    clr_log();
    do_start();
    xfer(32'd4);
    xfer(32'h1111_1111);
    xfer(32'h2222_2222);
    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h3333_3333;
    step();
    reset = 1'b0;
    chk_val("t5_rst_en",     64'(instr_wr_en), 64'd0);
    chk_val("t5_rst_cpurst", 64'(cpu_reset), 64'd1);
    chk_val("t5_rst_ready",  64'(s_ready), 64'd0);
    step();
    step();
    chk_val("t5_idle_ready", 64'(s_ready), 64'd0);
    chk_val("t5_nwr",        64'(wa_q.size()), 64'd2);
    s_valid = 1'b0;

    // Full-size program; extra words after the last must not be accepted.
    clr_log();
    do_start();
    xfer(32'd64);
    for (int i = 0; i < SIZE; i++) begin
      xfer(32'h0000_1000 + 32'(i));
    end
    chk_val("t6_last_en",    64'(instr_wr_en), 64'd1);
    chk_val("t6_last_addr",  64'(instr_wr_addr), 64'd252);
    chk_val("t6_last_data",  64'(instr_in), 64'h0000_103F);
    s_valid = 1'b1;
    s_data  = 32'hFFFF_FFFF;
    step();
    chk_val("t6_done",       64'(load_done), 64'd1);
    chk_val("t6_ready",      64'(s_ready), 64'd0);
    step();
    chk_val("t6_ready2",     64'(s_ready), 64'd0);
    chk_val("t6_nwr",        64'(wa_q.size()), 64'd64);
    for (int i = 0; i < wa_q.size(); i++) begin
      chk_val("t6_addr", 64'(wa_q[i]), 64'(i * 4));
      chk_val("t6_data", 64'(wd_q[i]), 64'(32'h0000_1000 + 32'(i)));
    end
    s_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bits per instruction word (fixed at 32).
REQ-002 SHALL have parameter SIZE, default 64: instruction memory depth in words; localparam LOGSIZE = clog2(SIZE).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request to begin (or restart) a program load.
REQ-006 SHALL have port s_valid, input, 1: upstream word stream valid.
REQ-007 SHALL have port s_data, input, WIDTH: upstream word (header or instruction).
REQ-008 SHALL have port s_ready, output, 1: loader accepts s_data this cycle.
REQ-009 SHALL have port instr_in, output, WIDTH: write data to the processor instruction memory write port.
REQ-010 SHALL have port instr_wr_addr, output, LOGSIZE+2: byte address to the instruction memory write port.
REQ-011 SHALL have port instr_wr_en, output, 1: instruction memory write strobe.
REQ-012 SHALL have port cpu_reset, output, 1: holds the processor in reset while high.
REQ-013 SHALL have port load_done, output, 1: program loaded, processor released.
REQ-014 SHALL have port load_err, output, 1: header word count exceeded SIZE.

Function
REQ-015 SHALL implement states IDLE, HEADER, LOAD, DRAIN, DONE, ERR.
REQ-016 Handshake SHALL occur on a cycle with s_valid=1 and s_ready=1; s_ready SHALL be 1 only in HEADER and LOAD.
REQ-017 IDLE: start=1 -> HEADER; otherwise stay.
REQ-018 HEADER: on handshake, latch N = s_data; N=0 -> DONE; N>SIZE -> ERR; else LOAD with word counter = 0.
REQ-019 LOAD: each handshake SHALL register a write: next cycle instr_wr_en=1, instr_in = accepted word, instr_wr_addr = counter*4; counter increments by 1.
REQ-020 LOAD: handshake of word N-1 -> DRAIN; DRAIN lasts exactly one cycle (the final write strobe) then -> DONE.
REQ-021 instr_wr_en SHALL be a single-cycle pulse per accepted instruction word and 0 in all other cycles; back-to-back handshakes SHALL produce back-to-back write pulses with no gaps.
REQ-022 A stalled upstream (s_valid=0) in HEADER or LOAD SHALL hold state, counter and outputs unchanged, with instr_wr_en=0.
REQ-023 cpu_reset SHALL be 1 in every state except DONE; it SHALL fall only after the final write pulse has completed.
REQ-024 load_done SHALL be 1 only in DONE; load_err SHALL be 1 only in ERR.
REQ-025 DONE or ERR: start=1 -> HEADER next cycle; cpu_reset reasserts and load_done/load_err clear in that cycle.
REQ-026 start SHALL be ignored in HEADER, LOAD and DRAIN.
REQ-027 N = SIZE SHALL be accepted; the last write address SHALL be (SIZE-1)*4; counter SHALL not wrap.
REQ-028 Words arriving after N accepted words SHALL not be accepted (s_ready=0) until a new start.

Reset
REQ-029 reset=1 SHALL force IDLE, counter=0, N=0, s_ready=0, instr_wr_en=0, instr_in=0, instr_wr_addr=0, cpu_reset=1, load_done=0, load_err=0 at the next edge.
REQ-030 reset asserted mid-load SHALL abort the load within one cycle; no further write pulses SHALL follow.
REQ-031 reset SHALL take priority over start and over any handshake in the same cycle.

Verification
REQ-032 start; header 3; words 0x00500093, 0x00A00113, 0x002081B3 streamed continuously -> three consecutive write pulses at addresses 0, 4, 8 with those data; one cycle later cpu_reset=0, load_done=1.
REQ-033 start; header 2; s_valid toggled 1,0,0,1 -> exactly two write pulses at addresses 0, 4, no write pulse during gaps, load_done=1 after the second.
REQ-034 start; header 65 (SIZE=64) -> no write pulse, load_err=1, cpu_reset=1; then start, header 1, word 0x00000013 -> load_err=0, one write at address 0, load_done=1.
REQ-035 start; header 0 -> DONE next cycle, no write pulse, cpu_reset=0.
REQ-036 start; header 4; after 2 words assert reset -> IDLE, cpu_reset=1, no further write pulses, s_ready=0.
REQ-037 start; header 64; 64 words -> last write at address 252, s_ready=0 afterward with s_valid held 1, load_done=1.
